rtc_disp_scan: RTL
==================

// Module: rtc_disp_scan
// PURPOSE
//  Display-scan stage downstream of rtcclock: consumes BCD time snapshots (HH:MM:SS) via valid/ready.
//  Time-multiplexes them onto a common-cathode 7-segment array on the user IO pads.
//  Provides tear-free frame update, PWM dimming, anti-ghost dead cycle and 1 Hz colon blink.
// PARAMETERS
//  NDIG        6   number of digits; digit 0 = seconds units, digit NDIG-1 = hours tens
//  SCAN_DIV_W  16  width of scan-rate prescaler
//  BRIGHT_W    4   width of PWM brightness control
// PORTS
//  wb_clk_i     in   1             system clock
//  wb_rst_ni    in   1             async active-low reset
//  time_vld_i   in   1             snapshot valid
//  time_rdy_o   out  1             snapshot ready (shadow register empty)
//  time_bcd_i   in   4*NDIG        BCD digits, [3:0] = digit 0
//  sec_tick_i   in   1             one-cycle pulse per second from rtcclock
//  scan_div_i   in   SCAN_DIV_W    cycles-per-slot minus 1
//  bright_i     in   BRIGHT_W      duty; all-ones = full on
//  disp_en_i    in   1             display enable
//  seg_o        out  7             segments a..g, active high
//  dp_o         out  1             decimal point / colon, active high
//  dig_o        out  NDIG          digit enables, one-hot or zero, active high
//  pad_oeb_o    out  NDIG+8        Caravel-style oeb for seg/dp/dig pads (0 = drive)
//  bad_bcd_o    out  1             active frame holds a non-BCD nibble
// BEHAVIOUR
//  Reset: seg_o=0, dp_o=0, dig_o=0, pad_oeb_o=all 1, time_rdy_o=1, bad_bcd_o=0; shadow/active regs=0; digit idx=0.
//  Handshake: accept on time_vld_i & time_rdy_o -> shadow loaded, shadow_full=1, time_rdy_o=0 next cycle.
//  Frame boundary = slot tick while idx==NDIG-1: shadow->active copy, shadow_full=0, bad_bcd_o recomputed from new active.
//  Accept and transfer in same cycle: transfer uses old shadow; new data lands in shadow, shadow_full stays 1.
//  No shadow pending at boundary: active unchanged.
//  Prescaler: counts 0..scan_div_i; slot tick when cnt>=scan_div_i, cnt->0. scan_div_i=0 -> tick every cycle.
//  Lowering scan_div_i below cnt gives an immediate tick (no wrap through 2^W).
//  Digit idx advances on slot tick, NDIG-1 wraps to 0.
//  Dead cycle: dig_o=0 for the cycle after each slot tick (anti-ghost).
//  PWM: free-running BRIGHT_W counter; lit = (pwm<bright_i) | (bright_i==all 1). bright_i=0 -> digit never lit.
//  Output latency: seg_o/dp_o/dig_o registered, 1 cycle after idx/pwm state.
//  Decode: 0-9 standard a..g patterns; nibble>9 -> g only ("-").
//  dp_o: blink flop toggles on sec_tick_i; dp_o = blink & lit & (idx==2 | idx==4).
//  disp_en_i=0: seg_o/dp_o/dig_o=0 next cycle, pad_oeb_o=all 1; scanning and handshake continue.
//  disp_en_i=1: pad_oeb_o=0 next cycle.
//  Reset mid-frame: all state returns to reset values immediately (async); pending shadow is discarded.
// CONFIGURATION
//  RTC_DISP_LZB_EN defined: leading-zero blanking; digit NDIG-1 reads 0 -> seg_o=0 and dig_o low in its slot.
//  RTC_DISP_LZB_EN undefined: digit NDIG-1 shows "0" like any other digit.
// STRUCTURE
//  rtc_disp_pkg: SEG_LUT[0:9] constants, SEG_DASH, NDIG_DEF, dig_idx_t typedef.
//  Sub-module rtc_bcd7seg: combinational nibble -> {seg[6:0], bad} decoder.
//  Top holds prescaler, idx counter, PWM counter, shadow/active regs, output flops.
// TESTING
//  Reset released, no snapshot -> dig_o walks 1,2,4..32 with dead cycles, seg_o=7'h3F ("0"), pad_oeb_o=0 once disp_en_i=1.
//  scan_div_i=3, bright_i=F, send 0x235959 -> after next frame boundary seg_o per slot = 9,5,9,5,3,2 patterns; each slot 4 cycles incl. 1 dead.
//  Hold time_vld_i with 0x000001 then 0x000002 back-to-back -> 2nd stalls (time_rdy_o=0) until boundary; no mixed-digit frame ever shown.
//  Send 0x0000A0 -> digit 1 shows g-only (7'h40), bad_bcd_o=1; next valid snapshot clears it at boundary.
//  bright_i=4 -> dig_o lit 4 of every 16 cycles within slot; bright_i=0 -> dig_o stays 0.
//  sec_tick_i pulses -> dp_o toggles on digits 2/4 only; RTC_DISP_LZB_EN build with 0x091500 blanks digit 5.

Source files
------------

// File: rtl/rtc_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_disp_pkg
//  Description : Shared constants and types for the rtc_disp_scan display
//                scanner: 7-segment glyph table, dash glyph, default digit
//                count and digit-index type.
//  Revision    : 1.0  initial release
// ============================================================================
package rtc_disp_pkg;

  localparam int NDIG_DEF = 6;

  // Segment order is {g,f,e,d,c,b,a}; bit 0 is segment a.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Shown for any nibble that is not a decimal digit.
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef logic [$clog2(NDIG_DEF)-1:0] dig_idx_t;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bcd7seg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bcd7seg
//  Description : Combinational BCD nibble to 7-segment decoder. Non-decimal
//                nibbles render as a dash and raise bad_o.
//  Revision    : 1.0  initial release
// ============================================================================
module rtc_bcd7seg
  import rtc_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o,
  output logic       bad_o
);

  // Table lookup for 0-9, dash plus error flag for everything else
  always_comb begin
    seg_o = SEG_DASH;
    bad_o = 1'b1;
    if (is_bcd(nib_i)) begin
      seg_o = SEG_LUT[nib_i];
      bad_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_disp_scan
//  Description : Time-multiplexed 7-segment scanner for BCD HH:MM:SS
//                snapshots. Double-buffered (shadow/active) for tear-free
//                frames, PWM dimming, one dead cycle per slot against
//                ghosting, blinking colon on digits 2 and 4.
//  Options     : define RTC_DISP_LZB_EN for leading-zero blanking of the
//                most significant digit.
//  Revision    : 1.0  initial release
// ============================================================================
module rtc_disp_scan
  import rtc_disp_pkg::*;
#(
  parameter int NDIG       = NDIG_DEF,
  parameter int SCAN_DIV_W = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  time_vld_i,
  output logic                  time_rdy_o,
  input  logic [4*NDIG-1:0]     time_bcd_i,
  input  logic                  sec_tick_i,
  input  logic [SCAN_DIV_W-1:0] scan_div_i,
  input  logic [BRIGHT_W-1:0]   bright_i,
  input  logic                  disp_en_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NDIG-1:0]       dig_o,
  output logic [NDIG+7:0]       pad_oeb_o,
  output logic                  bad_bcd_o
);

  localparam int              IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  // Scan state
  logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dead_q, dead_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic                  blink_q, blink_d;

  // Frame buffers
  logic [4*NDIG-1:0]     shadow_q, shadow_d;
  logic                  shadow_full_q, shadow_full_d;
  logic [4*NDIG-1:0]     active_q, active_d;

  // Output flops
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NDIG-1:0]       dig_q, dig_d;
  logic [NDIG+7:0]       oeb_q, oeb_d;

  logic                  w_slot_tick;
  logic                  w_frame_end;
  logic                  w_accept;
  logic                  w_lit;
  logic                  w_dp_pos;
  logic                  w_blank;
  logic [6:0]            w_cur_seg;
  logic [NDIG-1:0]       w_onehot;
  logic [6:0]            w_dig_seg [NDIG];
  logic [NDIG-1:0]       w_dig_bad;

  // Prescaler, digit index, dead-cycle marker, PWM ramp and colon blink
  always_comb begin
    // ">=" rather than "==" so lowering scan_div_i below cnt ticks at once
    w_slot_tick = (cnt_q >= scan_div_i);
    w_frame_end = w_slot_tick && (idx_q == IDX_LAST);
    cnt_d       = w_slot_tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (w_slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    dead_d  = w_slot_tick;
    pwm_d   = pwm_q + 1'b1;
    blink_d = blink_q ^ sec_tick_i;
  end

  // Snapshot handshake and shadow-to-active transfer at frame boundary
  always_comb begin
    w_accept      = time_vld_i & ~shadow_full_q;
    shadow_d      = w_accept ? time_bcd_i : shadow_q;
    active_d      = (w_frame_end & shadow_full_q) ? shadow_q : active_q;
    shadow_full_d = w_accept | (shadow_full_q & ~w_frame_end);
  end

  // One decoder per active digit; also feeds the frame-wide bad flag
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dec
    rtc_bcd7seg u_dec (
      .nib_i (active_q[4*gi +: 4]),
      .seg_o (w_dig_seg[gi]),
      .bad_o (w_dig_bad[gi])
    );
  end

  for (genvar gj = 0; gj < NDIG; gj++) begin : g_onehot
    assign w_onehot[gj] = (idx_q == IDX_W'(gj));
  end

  // Select the glyph of the digit currently being scanned
  always_comb begin
    w_cur_seg = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_cur_seg = w_dig_seg[i];
      end
    end
  end

`ifdef RTC_DISP_LZB_EN
  assign w_blank = (idx_q == IDX_LAST) && (active_q[4*NDIG-1 -: 4] == 4'd0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_lit    = (pwm_q < bright_i) | (&bright_i);
  assign w_dp_pos = (idx_q == IDX_W'(2)) | (idx_q == IDX_W'(4));

  // Next values of the registered pad outputs
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    dig_d = '0;
    oeb_d = '1;
    if (disp_en_i) begin
      oeb_d = '0;
      seg_d = w_blank ? 7'd0 : w_cur_seg;
      dp_d  = blink_q & w_lit & w_dp_pos;
      if (w_lit && !dead_q && !w_blank) begin
        dig_d = w_onehot;
      end
    end
  end

  // All state registers; reset discards any pending snapshot
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      dead_q        <= 1'b0;
      pwm_q         <= '0;
      blink_q       <= 1'b0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      dig_q         <= '0;
      oeb_q         <= '1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      dead_q        <= dead_d;
      pwm_q         <= pwm_d;
      blink_q       <= blink_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_q         <= dig_d;
      oeb_q         <= oeb_d;
    end
  end

  assign time_rdy_o = ~shadow_full_q;
  assign bad_bcd_o  = |w_dig_bad;
  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign dig_o      = dig_q;
  assign pad_oeb_o  = oeb_q;

endmodule
`default_nettype wire
